// File: rtl/wb_conbus_rr.sv
// wb_conbus_rr: round-robin Wishbone shared bus with address decode, unmapped-error and timeout
module wb_conbus_rr #(
    parameter int NM = 2,
    parameter int NS = 6,
    parameter int ADDR_W = 4,
    parameter logic [NS*ADDR_W-1:0] S_ADDR = {4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h0},
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NM*32-1:0]   m_adr_i,
    input  logic [NM*32-1:0]   m_dat_i,
    output logic [31:0]        m_dat_o,
    input  logic [NM*4-1:0]    m_sel_i,
    input  logic [NM-1:0]      m_we_i,
    input  logic [NM-1:0]      m_cyc_i,
    input  logic [NM-1:0]      m_stb_i,
    output logic [NM-1:0]      m_ack_o,
    output logic [NM-1:0]      m_err_o,
    output logic [31:0]        s_adr_o,
    output logic [31:0]        s_dat_o,
    output logic [3:0]         s_sel_o,
    output logic               s_we_o,
    output logic [NS-1:0]      s_cyc_o,
    output logic [NS-1:0]      s_stb_o,
    input  logic [NS*32-1:0]   s_dat_i,
    input  logic [NS-1:0]      s_ack_i
);
    localparam int IW = NM > 1 ? $clog2(NM) : 1;
    localparam int SW = NS > 1 ? $clog2(NS) : 1;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t            state, state_nx;
    logic [IW-1:0]     gnt_idx, gnt_nx, last_idx, last_nx, pick;
    logic [IW:0]       sum;
    logic              found, gnt_valid, cyc_k, stb_k, match, ack_s, to_hit, err_r, to_block;
    logic [SW-1:0]     midx;
    logic [ADDR_W-1:0] field;
    logic [31:0]       adr_k;
    logic [15:0]       to_cnt;

    assign gnt_valid = state == OWNED;
    assign adr_k     = m_adr_i[gnt_idx*32 +: 32];
    assign cyc_k     = gnt_valid & m_cyc_i[gnt_idx];
    assign stb_k     = cyc_k & m_stb_i[gnt_idx];
    assign field     = adr_k[31 -: ADDR_W];

    // Address decode of the granted master; the lowest matching table entry wins.
    always_comb begin
        match = 1'b0;
        midx  = '0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (field == S_ADDR[i*ADDR_W +: ADDR_W]) begin
                match = 1'b1;
                midx  = SW'(i);
            end
        end
    end

    assign ack_s  = gnt_valid & match & s_ack_i[midx];
    assign to_hit = (TIMEOUT != 0) && stb_k && match && !ack_s && to_cnt == 16'(TIMEOUT - 1);

    assign m_ack_o = (ack_s & ~err_r) ? NM'(1) << gnt_idx : '0;
    assign m_err_o = (gnt_valid & (err_r | to_hit)) ? NM'(1) << gnt_idx : '0;
    assign s_cyc_o = (cyc_k & match) ? NS'(1) << midx : '0;
    assign s_stb_o = (stb_k & match & ~to_block) ? NS'(1) << midx : '0;
    assign m_dat_o = (gnt_valid & match) ? s_dat_i[midx*32 +: 32] : '0;
    assign s_adr_o = gnt_valid ? adr_k : '0;
    assign s_dat_o = gnt_valid ? m_dat_i[gnt_idx*32 +: 32] : '0;
    assign s_sel_o = gnt_valid ? m_sel_i[gnt_idx*4 +: 4] : '0;
    assign s_we_o  = gnt_valid & m_we_i[gnt_idx];

    // Round-robin search starting after the last owner; rearbitrate only once the owner's cycle ends.
    always_comb begin
        state_nx = state;
        gnt_nx   = gnt_idx;
        last_nx  = last_idx;
        found    = 1'b0;
        pick     = '0;
        sum      = '0;
        for (int i = NM; i >= 1; i--) begin
            sum = {1'b0, last_idx} + (IW+1)'(i);
            if (sum >= (IW+1)'(NM)) sum = sum - (IW+1)'(NM);
            if (m_cyc_i[sum[IW-1:0]]) begin
                found = 1'b1;
                pick  = sum[IW-1:0];
            end
        end
        if (!cyc_k) begin
            state_nx = found ? OWNED : IDLE;
            gnt_nx   = found ? pick : gnt_idx;
            last_nx  = found ? pick : last_idx;
        end
    end

    // Arbiter state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            gnt_idx  <= '0;
            last_idx <= IW'(NM - 1);
        end else begin
            state    <= state_nx;
            gnt_idx  <= gnt_nx;
            last_idx <= last_nx;
        end
    end

    // Unmapped-access error pulse, ack watchdog and the one-cycle strobe block after a timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_r    <= 1'b0;
            to_cnt   <= '0;
            to_block <= 1'b0;
        end else begin
            err_r    <= stb_k & ~match & ~err_r;
            to_cnt   <= (stb_k & match & ~ack_s & ~to_hit & ~err_r) ? to_cnt + 16'd1 : '0;
            to_block <= to_hit;
        end
    end
endmodule

// File: tb/tb_wb_conbus_rr.sv
// tb_wb_conbus_rr: directed scenarios plus randomized traffic against a behavioural bus model
module tb_wb_conbus_rr;
    localparam int NM = 2;
    localparam int NS = 6;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NM*32-1:0] m_adr_i, m_dat_i;
    logic [31:0]      m_dat_o, s_adr_o, s_dat_o;
    logic [NM*4-1:0]  m_sel_i;
    logic [NM-1:0]    m_we_i, m_cyc_i, m_stb_i, m_ack_o, m_err_o;
    logic [3:0]       s_sel_o;
    logic             s_we_o;
    logic [NS-1:0]    s_cyc_o, s_stb_o, s_ack_i;
    logic [NS*32-1:0] s_dat_i;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    wb_conbus_rr #(.NM(NM), .NS(NS), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_sel_i(m_sel_i),
        .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
    );

    // Reference model: owner number (-1 = nobody), last owner, pending error, wait count, strobe block.
    int tbl [NS] = '{0, 2, 3, 4, 5, 6};
    int mo_owner, mo_last, mo_wait, n_owner, n_last, n_wait, e_dsl;
    bit mo_errp, mo_blk, n_errp, e_act, e_stb, e_tmo, e_sack;
    logic [31:0]   e_adr, e_wdat, e_dat;
    logic [3:0]    e_sel;
    logic          e_we;
    logic [NS-1:0] e_scyc, e_sstb;
    logic [NM-1:0] e_ack, e_err;

    function automatic int slave_of(input logic [31:0] a);
        for (int i = 0; i < NS; i++) if (int'(a[31:28]) == tbl[i]) return i;
        return -1;
    endfunction

    always_comb begin
        e_adr = '0; e_wdat = '0; e_sel = '0; e_we = 1'b0; e_dat = '0;
        e_scyc = '0; e_sstb = '0; e_ack = '0; e_err = '0;
        e_dsl = -1; e_act = 0; e_stb = 0; e_tmo = 0; e_sack = 0;
        if (mo_owner >= 0) begin
            e_adr  = m_adr_i[mo_owner*32 +: 32];
            e_wdat = m_dat_i[mo_owner*32 +: 32];
            e_sel  = m_sel_i[mo_owner*4 +: 4];
            e_we   = m_we_i[mo_owner];
            e_act  = m_cyc_i[mo_owner];
            e_stb  = e_act && m_stb_i[mo_owner];
            e_dsl  = slave_of(e_adr);
            if (e_dsl >= 0) begin
                e_sack = s_ack_i[e_dsl];
                e_dat  = s_dat_i[e_dsl*32 +: 32];
                e_scyc[e_dsl] = e_act;
                e_sstb[e_dsl] = e_stb && !mo_blk;
                e_tmo = e_stb && !e_sack && mo_wait == TO - 1;
            end
            e_ack[mo_owner] = e_sack && !mo_errp;
            e_err[mo_owner] = mo_errp || e_tmo;
        end
        n_errp  = e_stb && e_dsl < 0 && !mo_errp;
        n_wait  = (e_stb && e_dsl >= 0 && !e_sack && !e_tmo && !mo_errp) ? mo_wait + 1 : 0;
        n_owner = mo_owner;
        n_last  = mo_last;
        if (!e_act) begin
            n_owner = -1;
            for (int d = 1; d <= NM; d++)
                if (n_owner < 0 && m_cyc_i[(mo_last + d) % NM]) n_owner = (mo_last + d) % NM;
            if (n_owner >= 0) n_last = n_owner;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mo_owner <= -1; mo_last <= NM - 1; mo_wait <= 0; mo_errp <= 0; mo_blk <= 0;
        end else begin
            mo_owner <= n_owner; mo_last <= n_last; mo_wait <= n_wait; mo_errp <= n_errp; mo_blk <= e_tmo;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = '0; m_cyc_i = '0; m_stb_i = '0;
        s_ack_i = '0; s_dat_i = '0;
    endtask

    task automatic set_m(input int j, input logic cyc, input logic stb, input logic [31:0] adr,
                         input logic we, input logic [31:0] dat);
        m_cyc_i[j] = cyc; m_stb_i[j] = stb; m_adr_i[j*32 +: 32] = adr;
        m_we_i[j] = we; m_dat_i[j*32 +: 32] = dat; m_sel_i[j*4 +: 4] = 4'hF;
    endtask

    task automatic pulse_reset;
        idle_inputs();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_reset;
        step();
        m_cyc_i = '1; m_stb_i = '1; s_ack_i = '1; m_adr_i = {2{32'h2000_0000}}; s_dat_i = '1;
        #2;
        total++; if (s_cyc_o !== '0) begin bad++; $display("FAIL rst_scyc: got %b want 0", s_cyc_o); end
        total++; if (s_stb_o !== '0) begin bad++; $display("FAIL rst_sstb: got %b want 0", s_stb_o); end
        total++; if (m_ack_o !== '0) begin bad++; $display("FAIL rst_ack: got %b want 0", m_ack_o); end
        total++; if (m_err_o !== '0) begin bad++; $display("FAIL rst_err: got %b want 0", m_err_o); end
        total++; if (m_dat_o !== '0) begin bad++; $display("FAIL rst_mdat: got %h want 0", m_dat_o); end
        total++; if (s_adr_o !== '0) begin bad++; $display("FAIL rst_sadr: got %h want 0", s_adr_o); end
        idle_inputs();
        @(negedge clk); reset = 1'b0;
        #1;
        total++; if (s_stb_o !== '0) begin bad++; $display("FAIL rst_rel_sstb: got %b want 0", s_stb_o); end
    endtask

    task automatic test_read;
        step(); set_m(0, 1, 1, 32'h2000_0004, 0, 0); #2;
        total++; if (s_stb_o !== 6'b0) begin bad++; $display("FAIL rd_c0_stb: got %b want 000000", s_stb_o); end
        for (int c = 1; c <= 3; c++) begin
            step();
            s_ack_i = (c == 3) ? 6'b000010 : 6'b0;
            s_dat_i[32 +: 32] = (c == 3) ? 32'hA5A5_0001 : 32'h0;
            #2;
            total++; if (s_stb_o !== 6'b000010) begin bad++; $display("FAIL rd_stb c%0d: got %b want 000010", c, s_stb_o); end
            total++; if (s_adr_o !== 32'h2000_0004) begin bad++; $display("FAIL rd_adr c%0d: got %h want 20000004", c, s_adr_o); end
            total++; if (m_ack_o !== ((c == 3) ? 2'b01 : 2'b00)) begin bad++; $display("FAIL rd_ack c%0d: got %b", c, m_ack_o); end
        end
        total++; if (m_dat_o !== 32'hA5A5_0001) begin bad++; $display("FAIL rd_dat: got %h want a5a50001", m_dat_o); end
        step(); idle_inputs(); #2;
        total++; if (s_stb_o !== 6'b0 || m_ack_o !== 2'b0) begin bad++; $display("FAIL rd_end: stb %b ack %b want 0", s_stb_o, m_ack_o); end
    endtask

    task automatic test_arbitration;
        pulse_reset();
        step(); set_m(0, 1, 1, 32'h0000_0000, 0, 0); set_m(1, 1, 1, 32'h4000_0000, 0, 0); #2;
        step(); #2;
        total++; if (s_stb_o !== 6'b000001) begin bad++; $display("FAIL arb_first: got %b want 000001", s_stb_o); end
        step(); set_m(0, 0, 0, 32'h0, 0, 0); #2;
        total++; if (s_stb_o !== 6'b0) begin bad++; $display("FAIL arb_drop: got %b want 000000", s_stb_o); end
        step(); set_m(0, 1, 1, 32'h0000_0000, 0, 0); #2;
        total++; if (s_stb_o !== 6'b001000) begin bad++; $display("FAIL arb_hand: got %b want 001000", s_stb_o); end
        total++; if (s_adr_o !== 32'h4000_0000) begin bad++; $display("FAIL arb_hadr: got %h want 40000000", s_adr_o); end
        step(); #2;
        total++; if (s_stb_o !== 6'b001000) begin bad++; $display("FAIL arb_hold: got %b want 001000", s_stb_o); end
        step(); set_m(1, 0, 0, 32'h0, 0, 0); #2;
        step(); #2;
        total++; if (s_stb_o !== 6'b000001) begin bad++; $display("FAIL arb_back: got %b want 000001", s_stb_o); end
        step(); idle_inputs(); #2;
    endtask

    task automatic test_unmapped;
        step(); set_m(1, 1, 1, 32'hF000_0000, 0, 0); s_ack_i = '1; #2;
        step(); #2;
        total++; if (s_cyc_o !== 6'b0) begin bad++; $display("FAIL um_cyc: got %b want 000000", s_cyc_o); end
        total++; if (m_err_o !== 2'b00) begin bad++; $display("FAIL um_err_early: got %b want 00", m_err_o); end
        step(); #2;
        total++; if (m_err_o !== 2'b10) begin bad++; $display("FAIL um_err: got %b want 10", m_err_o); end
        total++; if (m_ack_o !== 2'b00) begin bad++; $display("FAIL um_ack: got %b want 00", m_ack_o); end
        total++; if (s_cyc_o !== 6'b0) begin bad++; $display("FAIL um_cyc2: got %b want 000000", s_cyc_o); end
        step(); idle_inputs(); #2;
        total++; if (m_err_o !== 2'b00) begin bad++; $display("FAIL um_err_end: got %b want 00", m_err_o); end
    endtask

    task automatic test_timeout;
        for (int r = 0; r < 2; r++) begin
            step(); set_m(0, 1, 1, 32'h3000_0000, 1, 32'hDEAD_BEE0 + r); #2;
            for (int c = 1; c <= TO; c++) begin
                step(); s_ack_i = (r == 1 && c == TO) ? 6'b000100 : 6'b0; #2;
                total++; if (s_stb_o !== 6'b000100) begin bad++; $display("FAIL to_stb r%0d c%0d: got %b", r, c, s_stb_o); end
                total++; if (m_err_o !== ((r == 0 && c == TO) ? 2'b01 : 2'b00)) begin bad++; $display("FAIL to_err r%0d c%0d: got %b", r, c, m_err_o); end
                total++; if (m_ack_o !== ((r == 1 && c == TO) ? 2'b01 : 2'b00)) begin bad++; $display("FAIL to_ack r%0d c%0d: got %b", r, c, m_ack_o); end
            end
            total++; if (s_we_o !== 1'b1 || s_dat_o !== 32'hDEAD_BEE0 + r) begin bad++; $display("FAIL to_wr r%0d: we %b dat %h", r, s_we_o, s_dat_o); end
            step(); s_ack_i = '0; #2;
            if (r == 0) begin
                total++; if (s_stb_o !== 6'b0) begin bad++; $display("FAIL to_block: got %b want 000000", s_stb_o); end
                total++; if (s_cyc_o !== 6'b000100) begin bad++; $display("FAIL to_cyc: got %b want 000100", s_cyc_o); end
            end
            step(); idle_inputs(); #2;
        end
    endtask

    task automatic test_reset_mid;
        step(); set_m(0, 1, 1, 32'h6000_0000, 0, 0); #2;
        step(); #2;
        total++; if (s_stb_o !== 6'b100000) begin bad++; $display("FAIL rm_stb: got %b want 100000", s_stb_o); end
        step(); s_ack_i = 6'b100000; s_dat_i[5*32 +: 32] = 32'h1234_5678;
        #1; reset = 1'b1; #1;
        total++; if (s_cyc_o !== 6'b0) begin bad++; $display("FAIL rm_cyc: got %b want 000000", s_cyc_o); end
        total++; if (s_stb_o !== 6'b0) begin bad++; $display("FAIL rm_sstb: got %b want 000000", s_stb_o); end
        total++; if (m_ack_o !== 2'b0) begin bad++; $display("FAIL rm_ack: got %b want 00", m_ack_o); end
        total++; if (m_err_o !== 2'b0) begin bad++; $display("FAIL rm_err: got %b want 00", m_err_o); end
        idle_inputs();
        #3; reset = 1'b0; #1;
        total++; if (s_cyc_o !== 6'b0) begin bad++; $display("FAIL rm_rel: got %b want 000000", s_cyc_o); end
        step(); set_m(0, 1, 1, 32'h0000_0010, 0, 0); set_m(1, 1, 1, 32'h2000_0000, 0, 0); #2;
        total++; if (s_stb_o !== 6'b0) begin bad++; $display("FAIL rm_idle: got %b want 000000", s_stb_o); end
        step(); #2;
        total++; if (s_adr_o !== 32'h0000_0010 || s_stb_o !== 6'b000001) begin bad++; $display("FAIL rm_rr: adr %h stb %b want 00000010 000001", s_adr_o, s_stb_o); end
        step(); idle_inputs(); #2;
    endtask

    task automatic test_back_to_back;
        pulse_reset();
        step(); set_m(0, 1, 1, 32'h0, 0, 0); set_m(1, 1, 1, 32'h5000_0000, 0, 0); #2;
        for (int c = 1; c <= 4; c++) begin
            step();
            m_adr_i[31:0] = 32'((c - 1) * 4);
            s_ack_i = 6'b000001;
            s_dat_i[31:0] = 32'hB000_0000 + 32'(c);
            #2;
            total++; if (m_ack_o !== 2'b01) begin bad++; $display("FAIL b2b_ack c%0d: got %b want 01", c, m_ack_o); end
            total++; if (m_dat_o !== 32'hB000_0000 + 32'(c)) begin bad++; $display("FAIL b2b_dat c%0d: got %h", c, m_dat_o); end
            total++; if (s_adr_o !== 32'((c - 1) * 4)) begin bad++; $display("FAIL b2b_adr c%0d: got %h", c, s_adr_o); end
        end
        step(); set_m(0, 0, 0, 32'h0, 0, 0); s_ack_i = '0; #2;
        total++; if (s_stb_o !== 6'b0 || m_ack_o !== 2'b0) begin bad++; $display("FAIL b2b_drop: stb %b ack %b", s_stb_o, m_ack_o); end
        step(); #2;
        total++; if (s_stb_o !== 6'b010000 || s_adr_o !== 32'h5000_0000) begin bad++; $display("FAIL b2b_m1: stb %b adr %h", s_stb_o, s_adr_o); end
        step(); idle_inputs(); #2;
    endtask

    task automatic test_random;
        logic [3:0] nibs [8] = '{4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h1, 4'hF};
        for (int n = 0; n < 600; n++) begin
            step();
            for (int j = 0; j < NM; j++) begin
                m_cyc_i[j] = ($urandom % 4) != 0;
                m_stb_i[j] = ($urandom % 4) != 0;
                m_we_i[j]  = 1'($urandom);
                m_sel_i[j*4 +: 4] = 4'($urandom);
                m_adr_i[j*32 +: 32] = {nibs[$urandom % 8], 28'($urandom)};
                m_dat_i[j*32 +: 32] = $urandom;
            end
            for (int i = 0; i < NS; i++) begin
                s_ack_i[i] = ($urandom % 5) == 0;
                s_dat_i[i*32 +: 32] = $urandom;
            end
            #2;
            total++; if (s_cyc_o !== e_scyc) begin bad++; $display("FAIL rnd_scyc n%0d: got %b want %b", n, s_cyc_o, e_scyc); end
            total++; if (s_stb_o !== e_sstb) begin bad++; $display("FAIL rnd_sstb n%0d: got %b want %b", n, s_stb_o, e_sstb); end
            total++; if (m_ack_o !== e_ack) begin bad++; $display("FAIL rnd_ack n%0d: got %b want %b", n, m_ack_o, e_ack); end
            total++; if (m_err_o !== e_err) begin bad++; $display("FAIL rnd_err n%0d: got %b want %b", n, m_err_o, e_err); end
            total++; if (m_dat_o !== e_dat) begin bad++; $display("FAIL rnd_mdat n%0d: got %h want %h", n, m_dat_o, e_dat); end
            total++; if (s_adr_o !== e_adr) begin bad++; $display("FAIL rnd_sadr n%0d: got %h want %h", n, s_adr_o, e_adr); end
            total++; if (s_dat_o !== e_wdat) begin bad++; $display("FAIL rnd_sdat n%0d: got %h want %h", n, s_dat_o, e_wdat); end
            total++; if (s_sel_o !== e_sel || s_we_o !== e_we) begin bad++; $display("FAIL rnd_selwe n%0d: got %h/%b want %h/%b", n, s_sel_o, s_we_o, e_sel, e_we); end
        end
        step(); idle_inputs(); #2;
    endtask

    initial begin
        idle_inputs();
        repeat (2) @(posedge clk);
        test_reset();
        test_read();
        test_arbitration();
        test_unmapped();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_conbus_rr.md
Name: wb_conbus_rr

Overview:
- Parametrised Wishbone shared-bus interconnect: NM masters, NS slaves, one transfer in flight at a time.
- Next generation of the current fixed 2-master/6-slave conbus. Adds round-robin arbitration, a programmable slave address table, an error response for unmapped addresses, and a bus-timeout watchdog.
- Sits between the LM32 I/D ports (plus future DMA masters) and the bram, uart, timer, gpio and SK6812RGBW peripherals.

Parameters:
- NM, 2, number of masters (1..8).
- NS, 6, number of slaves (1..16).
- ADDR_W, 4, number of upper address bits decoded (adr[31:32-ADDR_W]).
- S_ADDR, {4'h6,4'h5,4'h4,4'h3,4'h2,4'h0}, flattened NS*ADDR_W table; slave i occupies bits [i*ADDR_W +: ADDR_W].
- TIMEOUT, 1024, cycles a granted strobe may wait for ack before an error is forced; 0 disables; maximum 65535.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m_adr_i  in  NM*32  master addresses, master j at [j*32 +: 32]
- m_dat_i  in  NM*32  master write data
- m_dat_o  out  32  read data, broadcast to all masters
- m_sel_i  in  NM*4  byte selects
- m_we_i  in  NM  write enables
- m_cyc_i  in  NM  cycle requests
- m_stb_i  in  NM  strobes
- m_ack_o  out  NM  acks, at most one bit set
- m_err_o  out  NM  bus errors, at most one bit set
- s_adr_o  out  32  address of the granted master, broadcast
- s_dat_o  out  32  write data of the granted master, broadcast
- s_sel_o  out  4  byte selects, broadcast
- s_we_o  out  1  write enable, broadcast
- s_cyc_o  out  NS  per-slave cycle
- s_stb_o  out  NS  per-slave strobe
- s_dat_i  in  NS*32  slave read data
- s_ack_i  in  NS  slave acks

Behaviour:
- Reset values: gnt_valid=0, gnt_idx=0, last_idx=NM-1, err_r=0, to_cnt=0. All outputs are 0 during and immediately after reset.
- Reset is asynchronous. Asserting it mid-transfer aborts the transfer immediately: s_cyc_o/s_stb_o drop in the same cycle, no ack or err is delivered, and the interconnect never replays the transfer.
- Arbiter states:
  - IDLE (gnt_valid=0).
  - OWNED (gnt_valid=1, gnt_idx=k).
- Arbiter transitions:
  - IDLE, or OWNED with m_cyc_i[k]=0: on the clock edge, choose the first j with m_cyc_i[j]=1, searching last_idx+1, last_idx+2, ... modulo NM. Set gnt_idx=j, last_idx=j, gnt_valid=1. If no master requests, go to IDLE.
  - OWNED with m_cyc_i[k]=1: hold the grant. Ownership lasts the whole cycle, across back-to-back strobes.
- Grant latency: a master raising cyc while the bus is idle sees its strobe reach the slave 1 cycle later.
- Handover: the owner drops cyc in cycle t; the next owner drives the slave from cycle t+1. No idle cycle is inserted.
- Decode is combinational on the granted master's adr[31:32-ADDR_W].
  - Match is slave i where the field equals S_ADDR[i].
  - If entries overlap, the lowest i wins.
  - nomatch is the case where no entry matches.
- Slave outputs:
  - s_cyc_o[i] = gnt_valid & m_cyc_i[k] & match_i.
  - s_stb_o[i] = the same, also gated by m_stb_i[k].
  - All non-selected bits are 0.
  - s_adr_o, s_dat_o, s_sel_o, s_we_o are muxed from master k. When IDLE they are 0.
- Ack and read data:
  - m_ack_o[k] = s_ack_i[match] & gnt_valid. This path is combinational, with zero added latency.
  - m_dat_o = s_dat_i of the matched slave; 0 when nomatch or IDLE.
  - Non-owner masters always see ack=0 and err=0.
- Unmapped access: err_r <= gnt_valid & cyc & stb & nomatch & ~err_r. m_err_o[k] = err_r. This gives a single-cycle pulse, 1 cycle after the strobe. No slave cyc is asserted.
- Timeout (TIMEOUT>0):
  - to_cnt increments each cycle the granted, matched strobe is high with no ack.
  - to_cnt clears on ack, on err, when the strobe is low, or on grant change.
  - When to_cnt==TIMEOUT-1 and still no ack, m_err_o[k]=1 for that cycle, to_cnt clears, and s_stb_o is forced low in the following cycle.
- Simultaneous events:
  - If a slave ack coincides with the timeout cycle, the ack wins and no err is raised.
  - If err_r and any ack would coincide, err has priority; this case arises only for a nomatch access.

Test Plan:
- Reset released; m0 cyc/stb, adr=0x2000_0004, read. Slave 1 acks 2 cycles after its strobe with data 0xA5A5_0001. Required: s_stb_o=6'b000010 from cycle 1; m_ack_o=2'b01 on the slave's ack cycle; m_dat_o=0xA5A5_0001; s_stb_o=0 for every other slave throughout.
- m0 and m1 raise cyc in the same cycle after reset. Required: m0 is granted first (last_idx reset is 1). When m0 drops cyc at cycle t, m1 drives its slave at t+1. If m0 re-requests while m1 holds cyc, m0 is granted only after m1 drops cyc.
- m1 accesses 0xF000_0000. Required: s_cyc_o=0 throughout; m_err_o=2'b10 for exactly 1 cycle, 1 cycle after the strobe; m_ack_o stays 0.
- TIMEOUT=16; m0 writes 0x3000_0000 and the timer never acks. Required: m_err_o[0]=1 in the 16th strobe cycle; s_stb_o[2]=0 in the next cycle. Repeat with the ack arriving in the 16th cycle: ack is delivered, no err.
- Reset asserted while slave 5 has cyc/stb high awaiting ack. Required: s_cyc_o, s_stb_o, m_ack_o and m_err_o are 0 in the same cycle. After release the bus is IDLE and the next request is granted in round-robin order starting from master 0.
- m0 holds cyc over 4 back-to-back single-cycle-ack bram reads at 0x0000_0000..0x0000_000C while m1 requests. Required: all 4 acks go to m0, and m1 is granted in the cycle after m0 drops cyc.
